alu_share_ctrl: RTL and testbench

//  Sequencing controller that shares the single 32-bit ALU between two requesters
//  (port 0: execute stage, port 1: branch/address unit). Arbitrates round-robin,

---
 rtl/alu_share_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_alu_share_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_ctrl.sv
// -----------------------------------------------------------------------------
// alu_share_ctrl
//   Shares one combinational WIDTH-bit ALU between two requesters
//   (port 0: execute stage, port 1: branch/address unit).
//   A request is granted round-robin, its operands are latched, the ALU is
//   driven for one cycle, and the registered result, zero flag and error flag
//   are returned on the requester's own response channel with valid/ready.
//
// Ports
//   clk, rst                 clock; synchronous active-high reset
//   req0_*/req1_*            request channels: valid/ready, a, b, sel
//   rsp0_*/rsp1_*            response channels: valid/ready
//   rsp_data/zero/err        result payload shared by both response channels
//   alu_a/alu_b/alu_sel      operands and select driven to the ALU
//   alu_out/alu_is0          ALU result and its zero indication
//   busy                     high while a transaction is in EXEC or RESP
// -----------------------------------------------------------------------------
module alu_share_ctrl #(
    parameter int WIDTH   = 32,
    parameter int SEL_W   = 4,
    parameter int MAX_SEL = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [SEL_W-1:0] req0_sel,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [SEL_W-1:0] req1_sel,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_is0,
    output logic             busy
);

    localparam logic [SEL_W-1:0] MAX_SEL_C = SEL_W'(MAX_SEL);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             ptr;        // priority requester when both are valid
    logic             op_id;      // requester owning the transaction in flight
    logic             op_err;     // select code of the transaction was illegal
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [SEL_W-1:0] op_sel;

    logic             any_valid;
    logic             grant_id;
    logic             fire;
    logic             rsp_hs;
    logic [WIDTH-1:0] grant_a;
    logic [WIDTH-1:0] grant_b;
    logic [SEL_W-1:0] grant_sel;
    logic             grant_err;

    // ------------------------------------------------------------------------
    // Arbitration and payload selection
    // ------------------------------------------------------------------------
    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant_id = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = ptr;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
    end

    assign any_valid = req0_valid | req1_valid;
    assign fire      = (state == IDLE) && any_valid;
    assign grant_a   = grant_id ? req1_a   : req0_a;
    assign grant_b   = grant_id ? req1_b   : req0_b;
    assign grant_sel = grant_id ? req1_sel : req0_sel;
    assign grant_err = grant_sel > MAX_SEL_C;
    assign rsp_hs    = op_id ? rsp1_ready : rsp0_ready;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fire)   state_nxt = EXEC;
            EXEC:                state_nxt = RESP;
            RESP:    if (rsp_hs) state_nxt = IDLE;
            default:             state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = any_valid && !grant_id;
                req1_ready = any_valid &&  grant_id;
            end
            EXEC: begin
                busy = 1'b1;
            end
            RESP: begin
                busy       = 1'b1;
                rsp0_valid = !op_id;
                rsp1_valid =  op_id;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------------
    // Operand registers. An illegal select is latched as all-zero operands and
    // select 0, so the ALU sees a harmless operation and the ALU ports can be
    // driven straight from these registers at all times.
    // ------------------------------------------------------------------------
    // NOTE: the operand registers are reset because they drive the ALU ports
    // directly and those must read 0 out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a   <= '0;
            op_b   <= '0;
            op_sel <= '0;
            op_id  <= 1'b0;
            op_err <= 1'b0;
        end else if (fire) begin
            op_a   <= grant_err ? '0 : grant_a;
            op_b   <= grant_err ? '0 : grant_b;
            op_sel <= grant_err ? '0 : grant_sel;
            op_id  <= grant_id;
            op_err <= grant_err;
        end
    end

    assign alu_a   = op_a;
    assign alu_b   = op_b;
    assign alu_sel = op_sel;

    // ------------------------------------------------------------------------
    // Result capture at the end of EXEC; held through RESP and IDLE
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_data <= '0;
            rsp_zero <= 1'b0;
            rsp_err  <= 1'b0;
        end else if (state == EXEC) begin
            rsp_data <= op_err ? '0   : alu_out;
            rsp_zero <= op_err ? 1'b1 : alu_is0;
            rsp_err  <= op_err;
        end
    end

    // The requester just served loses priority; reset returns it to port 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (state == RESP && rsp_hs) begin
            ptr <= ~op_id;
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_share_ctrl
//   Self-checking bench for alu_share_ctrl. Provides a behavioural stand-in
//   for the shared ALU, applies a table of single-requester vectors, a few
//   hand-written arbitration/reset sequences and a randomized phase whose
//   expected grant and results come from a small reference model.
// -----------------------------------------------------------------------------
module tb_alu_share_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   req_valid;
    logic [W-1:0] req_a   [2];
    logic [W-1:0] req_b   [2];
    logic [3:0]   req_sel [2];
    logic [1:0]   rsp_ready;
    logic         req0_ready, req1_ready;
    logic         rsp0_valid, rsp1_valid;
    logic [W-1:0] rsp_data;
    logic         rsp_zero, rsp_err, busy;
    logic [W-1:0] alu_a, alu_b, alu_out;
    logic [3:0]   alu_sel;
    logic         alu_is0;

    int n_tests = 0;
    int n_fail  = 0;
    bit prio    = 1'b0;   // model: requester preferred when both are valid

    alu_share_ctrl #(.WIDTH(W), .SEL_W(4), .MAX_SEL(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req_valid[0]),
        .req0_ready (req0_ready),
        .req0_a     (req_a[0]),
        .req0_b     (req_b[0]),
        .req0_sel   (req_sel[0]),
        .req1_valid (req_valid[1]),
        .req1_ready (req1_ready),
        .req1_a     (req_a[1]),
        .req1_b     (req_b[1]),
        .req1_sel   (req_sel[1]),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp_ready[0]),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp_ready[1]),
        .rsp_data   (rsp_data),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_out    (alu_out),
        .alu_is0    (alu_is0),
        .busy       (busy)
    );

    initial forever #5 clk = ~clk;

    // Behavioural ALU: 0 AND, 1 OR, 2 XOR, 3 NOR, 4 NOT A, 5 ADD, 6 SUB,
    // 7 INC A, 8 signed SLT.
    function automatic logic [W-1:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [3:0] s);
        logic [W-1:0] r;
        r = '0;
        case (s)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd2: r = a ^ b;
            4'd3: r = ~(a | b);
            4'd4: r = ~a;
            4'd5: r = a + b;
            4'd6: r = a - b;
            4'd7: r = a + 32'd1;
            4'd8: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: r = '0;
        endcase
        return r;
    endfunction

    always_comb alu_out = alu_ref(alu_a, alu_b, alu_sel);
    assign alu_is0 = (alu_out == '0);

    function automatic logic rdy(input bit p);
        return p ? req1_ready : req0_ready;
    endfunction

    function automatic logic rvld(input bit p);
        return p ? rsp1_valid : rsp0_valid;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit p, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [3:0] s);
        req_valid[p] = 1'b1;
        req_a[p]     = a;
        req_b[p]     = b;
        req_sel[p]   = s;
    endtask

    task automatic do_reset();
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        for (int i = 0; i < 2; i++) begin
            req_a[i] = '0; req_b[i] = '0; req_sel[i] = '0;
        end
        rst = 1'b1;
        tick();
        tick();
        rst  = 1'b0;
        prio = 1'b0;
    endtask

    // One full transaction on requester p, whose request is already driven
    // (called at an IDLE cycle). Checks accept, EXEC drive, RESP payload for
    // hold+1 cycles, then completes the response handshake.
    task automatic serve(input bit p, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [3:0] s, input int hold, input bit poke,
                         input logic [W-1:0] ed, input logic ez, input logic ee);
        #1;
        check1("accept_ready", rdy(p), 1'b1);
        check1("accept_other_ready", rdy(~p), 1'b0);
        check1("accept_busy", busy, 1'b0);
        tick();
        // Winner drops valid; its payload is scrambled to prove it was latched.
        req_valid[p] = 1'b0;
        req_a[p]     = $urandom;
        req_b[p]     = $urandom;
        req_sel[p]   = 4'($urandom);
        if (poke) set_req(~p, $urandom, $urandom, 4'($urandom_range(0, 8)));
        #1;
        check1("exec_busy", busy, 1'b1);
        check("exec_alu_a", alu_a, ee ? '0 : a);
        check("exec_alu_b", alu_b, ee ? '0 : b);
        check("exec_alu_sel", {28'd0, alu_sel}, ee ? 32'd0 : {28'd0, s});
        check1("exec_rsp_valid", rsp0_valid | rsp1_valid, 1'b0);
        check1("exec_ready", req0_ready | req1_ready, 1'b0);
        tick();
        for (int i = 0; i <= hold; i++) begin
            if (i > 0) tick();
            check1("resp_valid", rvld(p), 1'b1);
            check1("resp_other_valid", rvld(~p), 1'b0);
            check1("resp_busy", busy, 1'b1);
            check("resp_data", rsp_data, ed);
            check1("resp_zero", rsp_zero, ez);
            check1("resp_err", rsp_err, ee);
            check1("resp_ready_blocked", req0_ready | req1_ready, 1'b0);
        end
        rsp_ready[p] = 1'b1;
        tick();
        rsp_ready[p] = 1'b0;
        check1("done_busy", busy, 1'b0);
        check1("done_valid", rvld(p), 1'b0);
        check("done_data_held", rsp_data, ed);
        prio = ~p;
    endtask

    typedef struct {
        bit           port;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [3:0]   sel;
        int           hold;
        bit           poke;
        logic [W-1:0] exp_d;
        logic         exp_z;
        logic         exp_e;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        // port, a, b, sel, hold, poke, data, zero, err
        vecs.push_back('{1'b0, 32'd5,         32'd7,         4'd5,  0, 1'b0, 32'd12,        1'b0, 1'b0});
        vecs.push_back('{1'b0, 32'h7FFF_FFFF, 32'd0,         4'd7,  5, 1'b1, 32'h8000_0000, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 32'h1234,      32'h5678,      4'hC,  0, 1'b0, 32'd0,         1'b1, 1'b1});
        vecs.push_back('{1'b1, 32'd3,         32'd3,         4'd6,  1, 1'b0, 32'd0,         1'b1, 1'b0});
        vecs.push_back('{1'b1, 32'hFFFF_FFFF, 32'd2,         4'd8,  0, 1'b0, 32'd1,         1'b0, 1'b0});
        vecs.push_back('{1'b0, 32'd2,         32'hFFFF_FFFF, 4'd8,  2, 1'b1, 32'd0,         1'b1, 1'b0});
        vecs.push_back('{1'b0, 32'hFFFF_FFFF, 32'd1,         4'd5,  0, 1'b0, 32'd0,         1'b1, 1'b0});
        vecs.push_back('{1'b1, 32'hAAAA_5555, 32'd1,         4'd9,  0, 1'b0, 32'd0,         1'b1, 1'b1});
        vecs.push_back('{1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd0,  0, 1'b0, 32'hF000_F000, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 32'h8000_0000, 32'd1,         4'd6,  1, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 32'd0,         32'd0,         4'hF,  0, 1'b0, 32'd0,         1'b1, 1'b1});

        // ---- reset state ----
        do_reset();
        check1("rst_req0_ready", req0_ready, 1'b0);
        check1("rst_req1_ready", req1_ready, 1'b0);
        check1("rst_rsp0_valid", rsp0_valid, 1'b0);
        check1("rst_rsp1_valid", rsp1_valid, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check1("rst_rsp_zero", rsp_zero, 1'b0);
        check1("rst_rsp_err", rsp_err, 1'b0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_b", alu_b, 32'd0);
        check("rst_alu_sel", {28'd0, alu_sel}, 32'd0);

        // ---- both valid after reset: port 0 first, then alternation ----
        set_req(1'b0, 32'd3, 32'd3, 4'd6);
        set_req(1'b1, 32'hFFFF_FFFF, 32'd2, 4'd8);
        serve(1'b0, 32'd3, 32'd3, 4'd6, 0, 1'b0, 32'd0, 1'b1, 1'b0);
        set_req(1'b0, 32'd1, 32'd1, 4'd5);            // port 0 returns at once
        serve(1'b1, 32'hFFFF_FFFF, 32'd2, 4'd8, 0, 1'b0, 32'd1, 1'b0, 1'b0);
        set_req(1'b1, 32'h10, 32'h01, 4'd2);
        serve(1'b0, 32'd1, 32'd1, 4'd5, 0, 1'b0, 32'd2, 1'b0, 1'b0);
        serve(1'b1, 32'h10, 32'h01, 4'd2, 0, 1'b0, 32'h11, 1'b0, 1'b0);
        req_valid = 2'b00;
        tick();

        // ---- table vectors ----
        foreach (vecs[i]) begin
            set_req(vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].sel);
            serve(vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].hold, vecs[i].poke,
                  vecs[i].exp_d, vecs[i].exp_z, vecs[i].exp_e);
            req_valid = 2'b00;
            tick();
        end

        // ---- reset while a transaction is in EXEC ----
        do_reset();
        set_req(1'b1, 32'd1, 32'd2, 4'd5);
        #1;
        check1("rstx_accept", req1_ready, 1'b1);
        tick();
        req_valid[1] = 1'b0;
        check1("rstx_in_exec", busy, 1'b1);
        rst = 1'b1;
        tick();
        rst  = 1'b0;
        prio = 1'b0;
        check1("rstx_idle", busy, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check1("rstx_no_rsp1", rsp1_valid, 1'b0);
            check1("rstx_no_rsp0", rsp0_valid, 1'b0);
        end
        set_req(1'b0, 32'd2, 32'd2, 4'd5);
        set_req(1'b1, 32'd9, 32'd4, 4'd6);
        serve(1'b0, 32'd2, 32'd2, 4'd5, 0, 1'b0, 32'd4, 1'b0, 1'b0);
        serve(1'b1, 32'd9, 32'd4, 4'd6, 0, 1'b0, 32'd5, 1'b0, 1'b0);
        req_valid = 2'b00;
        tick();

        // ---- randomized traffic against the reference model ----
        for (int n = 0; n < 40; n++) begin
            int           v;
            bit           p;
            logic [W-1:0] ra [2];
            logic [W-1:0] rb [2];
            logic [3:0]   rs [2];
            logic [W-1:0] ed;
            logic         ee;
            v = int'($urandom_range(1, 3));
            for (int k = 0; k < 2; k++) begin
                ra[k] = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom;
                rb[k] = ($urandom_range(0, 3) == 0) ? ra[k] : $urandom;
                rs[k] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(9, 15))
                                                    : 4'($urandom_range(0, 8));
                if (v[k]) set_req(k[0], ra[k], rb[k], rs[k]);
            end
            p  = (v == 3) ? prio : (v == 2);
            ee = (rs[p] > 4'd8);
            ed = ee ? '0 : alu_ref(ra[p], rb[p], rs[p]);
            serve(p, ra[p], rb[p], rs[p], int'($urandom_range(0, 3)), 1'b0, ed, (ed == '0), ee);
            if (v == 3) check1("rand_waiter_next", rdy(~p), 1'b1);
            req_valid = 2'b00;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
